// File: rtl/riscv_div_pkg.sv
`default_nettype none
// ============================================================
// riscv_div_pkg : funct3 codes and FSM states for the divider
// Rev 1.0
// ============================================================
package riscv_div_pkg;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/riscv_div_unit_step.sv
`default_nettype none
// ============================================================
// div_restore_step : one radix-2 restoring division iteration
// Rev 1.0
// ============================================================
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // Shifted remainder is always below 2*divisor, so the top bit of the
  // (WIDTH+1)-bit difference is exactly the borrow.
  assign w_shift  = {rem, dividend_msb};
  assign w_diff   = w_shift - {1'b0, divisor};
  assign q_bit    = ~w_diff[WIDTH];
  assign rem_next = q_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/riscv_div_unit.sv
`default_nettype none
// ============================================================
// riscv_div_unit : iterative DIV/DIVU/REM/REMU with handshakes
// Rev 1.0
// ============================================================
module riscv_div_unit
  import riscv_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] inst,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             div_by_zero,
  output logic             busy
);

  localparam logic [WIDTH-1:0] C_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] C_ONES    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] C_MIN     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_dividend, r_divisor, r_rem, r_out;
  logic [CNT_W-1:0] r_count;
  logic             r_is_rem, r_neg_q, r_neg_r, r_dbz;

  logic [2:0]       w_f3;
  logic             w_is_rem, w_is_signed, w_a_neg, w_b_neg;
  logic             w_b_zero, w_ovf, w_accept, w_calc_last;
  logic [WIDTH-1:0] w_a_abs, w_b_abs, w_rem_next, w_quot_raw, w_result;
  logic             w_q_bit;
  logic             w_unused_inst;

  assign w_f3          = inst[14:12];
  assign w_unused_inst = ^{inst[WIDTH-1:15], inst[11:0]};
  // funct3[2]=0 falls through to DIVU: unsigned, quotient
  assign w_is_rem      = w_f3[2] & w_f3[1];
  assign w_is_signed   = w_f3[2] & ~w_f3[0];
  assign w_a_neg       = w_is_signed & a[WIDTH-1];
  assign w_b_neg       = w_is_signed & b[WIDTH-1];
  assign w_a_abs       = w_a_neg ? (~a + C_ONE) : a;
  assign w_b_abs       = w_b_neg ? (~b + C_ONE) : b;
  assign w_b_zero      = (b == '0);
  assign w_ovf         = w_is_signed & (a == C_MIN) & (b == C_ONES);
  assign w_accept      = in_valid & (r_state == S_IDLE) & ~flush;
  assign w_calc_last   = (r_count == C_LAST);

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem          (r_rem),
    .dividend_msb (r_dividend[WIDTH-1]),
    .divisor      (r_divisor),
    .rem_next     (w_rem_next),
    .q_bit        (w_q_bit)
  );

  assign w_quot_raw = {r_dividend[WIDTH-2:0], w_q_bit};
  assign w_result   = r_is_rem ? (r_neg_r ? (~w_rem_next + C_ONE) : w_rem_next)
                               : (r_neg_q ? (~w_quot_raw + C_ONE) : w_quot_raw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (w_accept) w_state_next = (w_b_zero | w_ovf) ? S_DONE : S_CALC;
      end
      S_CALC: if (w_calc_last) w_state_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (flush) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_out      <= '0;
      r_count    <= '0;
      r_is_rem   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dbz      <= 1'b0;
    end else if (w_accept) begin
      r_is_rem   <= w_is_rem;
      r_neg_q    <= w_a_neg ^ w_b_neg;
      r_neg_r    <= w_a_neg;
      r_dividend <= w_a_abs;
      r_divisor  <= w_b_abs;
      r_rem      <= '0;
      r_count    <= '0;
      r_dbz      <= w_b_zero;
      if (w_b_zero)   r_out <= w_is_rem ? a : C_ONES;
      else if (w_ovf) r_out <= w_is_rem ? '0 : a;
    end else if (r_state == S_CALC && !flush) begin
      r_rem      <= w_rem_next;
      r_dividend <= w_quot_raw;
      r_count    <= r_count + C_CNT_ONE;
      if (w_calc_last) r_out <= w_result;
    end
  end

  assign out         = r_out;
  assign div_by_zero = r_dbz;

endmodule
`default_nettype wire
